// File: rtl/tb_obi_initiator.sv
// Bench-side OBI data-bus initiator: replays sequencer commands onto the core's data port.
// Optional grant-wait watchdog compiled in with TB_OBI_INITIATOR_TIMEOUT_EN.

// Small synchronous FIFO used for in-order response bookkeeping.
// Latency: read data is valid combinationally from the head entry whenever not empty.
// Backpressure: pushes while full and pops while empty are ignored.
module tb_obi_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end
endmodule

// Drives OBI req/addr/we/be/wdata from accepted commands and returns tagged responses.
// Latency: command accept -> req next cycle; rvalid -> rsp_valid_o next cycle.
// Backpressure: cmd_ready_o low while an ungranted request is held or the outstanding limit is reached; responses are never stalled.
module tb_obi_initiator #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_be_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        rsp_valid_o,
    output logic        rsp_we_o,
    output logic [31:0] rsp_rdata_o,
    output logic [2:0]  outstanding_o,
    output logic        err_o,
    output logic        timeout_o
);
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [2:0]  outs_q, outs_d;
    logic        rsp_valid_q;
    logic        rsp_we_q;
    logic [31:0] rsp_rdata_q;
    logic        err_q;

    logic        grant;
    logic        accept;
    logic        rsp_ok;
    logic        tag_head;
    logic        fifo_full;
    logic        fifo_empty;

    assign data_req_o   = (state_q == REQ);
    assign data_addr_o  = addr_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;

    assign grant = data_req_o && data_gnt_i;
    // The pending request is charged against the limit; a same-cycle rvalid is not credited.
    assign cmd_ready_o = (!data_req_o || data_gnt_i)
                       && ((32'(outs_q) + 32'(data_req_o)) < MAX_OUTSTANDING);
    assign accept = cmd_valid_i && cmd_ready_o;
    // A response with nothing outstanding is a protocol error and produces no response.
    assign rsp_ok = data_rvalid_i && (outs_q != 3'd0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        outs_d  = outs_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    state_d = accept ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            addr_d  = cmd_addr_i;
            wdata_d = cmd_wdata_i;
            be_d    = cmd_be_i;
            we_d    = cmd_we_i;
        end

        case ({grant, rsp_ok})
            2'b10:   outs_d = outs_q + 3'd1;
            2'b01:   outs_d = outs_q - 3'd1;
            default: outs_d = outs_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            outs_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            we_q        <= we_d;
            outs_q      <= outs_d;
            rsp_valid_q <= rsp_ok;
            rsp_we_q    <= rsp_ok && tag_head;
            rsp_rdata_q <= (rsp_ok && !tag_head) ? data_rdata_i : 32'h0;
            err_q       <= err_q || (data_rvalid_i && (outs_q == 3'd0));
        end
    end

    // OBI responses return in grant order, so a 1-bit FIFO recovers the type of each response.
    tb_obi_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_type_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .wdata_i (we_q),
        .pop_i   (rsp_ok),
        .rdata_o (tag_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    logic unused_fifo_status;
    assign unused_fifo_status = fifo_full ^ fifo_empty;

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_we_o      = rsp_we_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign outstanding_o = outs_q;
    assign err_o         = err_q;

`ifdef TB_OBI_INITIATOR_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;

    // Counter idles at zero, so it starts from zero on every entry to REQ; it saturates at the limit.
    always_comb begin
        wait_d    = wait_q;
        timeout_d = timeout_q;
        if ((state_q == IDLE) || data_gnt_i) begin
            wait_d = '0;
        end else if (32'(wait_q) < TIMEOUT_CYCLES) begin
            wait_d = wait_q + WAIT_W'(1);
            if ((32'(wait_q) + 32'd1) >= TIMEOUT_CYCLES) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_o = 1'b0;
`endif
endmodule
